// File: rtl/addsub_pkg.sv
// Shared types and constants for the bit-serial add/subtract sequencer.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Operation select, same sense as the add_sub cell enable.
    localparam logic OP_ADD = 1'b1;
    localparam logic OP_SUB = 1'b0;

endpackage

// File: rtl/add_sub.sv
// 1-bit add/subtract cell: full adder and full subtractor sharing inputs.
// en = 1 selects add (sum/carry valid), en = 0 selects subtract (diff/burrow valid);
// the unselected pair is driven to 0.
module add_sub (
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic en,
    output logic sum,
    output logic carry,
    output logic diff,
    output logic burrow
);

    logic axb;

    // Full-adder / full-subtractor equations, gated by the operation select
    always_comb begin
        axb    = a ^ b;
        sum    = en & (axb ^ cin);
        carry  = en & ((a & b) | (cin & axb));
        diff   = ~en & (axb ^ cin);
        burrow = ~en & ((~a & b) | (~axb & cin));
    end

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial WIDTH-bit add/subtract sequencer around one add_sub cell.
// Operands are shifted out LSB first, one bit per clock; the carry/borrow
// is held in a flop between bits and results are shifted in from the top.
module serial_addsub_ctrl
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t         state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic           op_r;
    logic           cy;
    logic [CW-1:0]  cnt;

    logic cell_sum;
    logic cell_carry;
    logic cell_diff;
    logic cell_burrow;
    logic bit_out;
    logic cy_out;

    add_sub u_cell (
        .a      (a_sh[0]),
        .b      (b_sh[0]),
        .cin    (cy),
        .en     (op_r),
        .sum    (cell_sum),
        .carry  (cell_carry),
        .diff   (cell_diff),
        .burrow (cell_burrow)
    );

    // Pick the result bit and carry/borrow for the latched operation
    always_comb begin
        bit_out = (op_r == OP_ADD) ? cell_sum   : cell_diff;
        cy_out  = (op_r == OP_ADD) ? cell_carry : cell_burrow;
    end

    // Status flags decode straight from registered state
    assign busy = (state == RUN);
    assign done = (state == DONE);

    // Sequencer: operand load, per-bit shifting, carry flop and counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            op_r   <= 1'b0;
            cy     <= 1'b0;
            cnt    <= '0;
            result <= '0;
            cout   <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        op_r   <= op;
                        cy     <= 1'b0;
                        cnt    <= '0;
                        result <= '0;
                        state  <= RUN;
                    end else begin
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    result <= {bit_out, result[WIDTH-1:1]};
                    cy     <= cy_out;
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        cout  <= cy_out;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Directed bench for serial_addsub_ctrl at WIDTH = 8.
module tb_serial_addsub_ctrl;
    import addsub_pkg::*;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;

    int total;
    int bad;
    logic prev_cout;

    serial_addsub_ctrl #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One operation from start to done; optional stray start during RUN.
    task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                          input logic opv, input logic [7:0] er, input logic ec,
                          input bit inject);
        int cycles;
        int busy_n;
        @(negedge clk);
        start = 1'b1; a = av; b = bv; op = opv;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, " clr"}, 32'(result), 32'h0);
        check({tag, " cout_hold"}, 32'(cout), 32'(prev_cout));
        cycles = 0;
        busy_n = 0;
        while (!done && cycles < 3 * WIDTH) begin
            if (busy) busy_n++;
            if (inject && cycles == 2) begin
                start = 1'b1; a = 8'hFF; b = 8'hFF; op = OP_SUB;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cycles++;
        end
        start = 1'b0;
        check({tag, " done"}, 32'(done), 32'h1);
        check({tag, " latency"}, 32'(cycles), 32'(WIDTH));
        check({tag, " busy_cycles"}, 32'(busy_n), 32'(WIDTH));
        check({tag, " busy_at_done"}, 32'(busy), 32'h0);
        check({tag, " result"}, 32'(result), 32'(er));
        check({tag, " cout"}, 32'(cout), 32'(ec));
        prev_cout = ec;
        @(posedge clk); #1;
        check({tag, " done_pulse"}, 32'(done), 32'h0);
        check({tag, " idle"}, 32'(busy), 32'h0);
    endtask

    initial begin
        int cycles;
        int done_seen;
        total = 0;
        bad = 0;
        prev_cout = 1'b0;
        rst_n = 1'b0;
        start = 1'b0;
        op = OP_ADD;
        a = '0;
        b = '0;

        #2;
        check("rst busy", 32'(busy), 32'h0);
        check("rst done", 32'(done), 32'h0);
        check("rst result", 32'(result), 32'h0);
        check("rst cout", 32'(cout), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op("add5a3c", 8'h5A, 8'h3C, OP_ADD, 8'h96, 1'b0, 1'b0);
        run_op("addff01", 8'hFF, 8'h01, OP_ADD, 8'h00, 1'b1, 1'b0);
        run_op("add0000", 8'h00, 8'h00, OP_ADD, 8'h00, 1'b0, 1'b0);
        run_op("sub1001", 8'h10, 8'h01, OP_SUB, 8'h0F, 1'b0, 1'b0);
        run_op("sub0102", 8'h01, 8'h02, OP_SUB, 8'hFF, 1'b1, 1'b0);
        run_op("ignore",  8'h12, 8'h34, OP_ADD, 8'h46, 1'b0, 1'b1);

        // Abort mid-run with reset
        @(negedge clk);
        start = 1'b1; a = 8'hAA; b = 8'h55; op = OP_SUB;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        check("abort busy_before", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        check("abort busy", 32'(busy), 32'h0);
        check("abort done", 32'(done), 32'h0);
        check("abort result", 32'(result), 32'h0);
        check("abort cout", 32'(cout), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        repeat (WIDTH + 2) begin
            @(posedge clk); #1;
            if (done) done_seen++;
        end
        check("abort no_done", 32'(done_seen), 32'h0);
        prev_cout = 1'b0;
        run_op("add0304", 8'h03, 8'h04, OP_ADD, 8'h07, 1'b0, 1'b0);

        // Back-to-back: start held during the DONE cycle
        @(negedge clk);
        start = 1'b1; a = 8'h01; b = 8'h01; op = OP_ADD;
        @(posedge clk); #1;
        start = 1'b0;
        cycles = 0;
        while (!done && cycles < 3 * WIDTH) begin
            @(posedge clk); #1;
            cycles++;
        end
        check("b2b first_latency", 32'(cycles), 32'(WIDTH));
        check("b2b first_result", 32'(result), 32'h02);
        check("b2b first_cout", 32'(cout), 32'h0);
        start = 1'b1; a = 8'h80; b = 8'h80; op = OP_ADD;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b no_gap", 32'(busy), 32'h1);
        check("b2b clr", 32'(result), 32'h0);
        check("b2b cout_hold", 32'(cout), 32'h0);
        cycles = 0;
        while (!done && cycles < 3 * WIDTH) begin
            @(posedge clk); #1;
            cycles++;
        end
        check("b2b second_latency", 32'(cycles), 32'(WIDTH));
        check("b2b second_result", 32'(result), 32'h00);
        check("b2b second_cout", 32'(cout), 32'h1);
        @(posedge clk); #1;
        check("b2b done_pulse", 32'(done), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
